fram_state_logger: RTL and testbench

Persists snapshots of the pet's internal state to the external SPI FRAM, the write-side counterpart of the existing FRAM read/speech path. On each `start` request it latches emotional state, action, development stage and neurotransmitter level, then acquires the shared SPI bus, issues WREN and WRITE, and stores a 4-byte record into a ring of slots. It runs on the slow model clock and shares sck/cs/mosi with the speech reader through a req/gnt handshake.

---
 rtl/fram_state_logger_pkg.sv | 42 ++++
 rtl/fram_state_logger_if.sv | 39 +++
 rtl/fram_state_logger_shifter.sv | 78 +++++++
 rtl/fram_state_logger.sv | 137 +++++++++++++
 tb/tb_fram_state_logger.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/fram_state_logger_pkg.sv
// Shared FRAM definitions: opcodes, snapshot record layout and the
// logger state encoding, also used by the speech reader.
package fram_pkg;

   localparam logic [7:0] FRAM_OP_WREN  = 8'h06;
   localparam logic [7:0] FRAM_OP_WRITE = 8'h02;
   localparam logic [7:0] FRAM_OP_READ  = 8'h03;

   localparam int SNAPSHOT_BYTES = 4;
   localparam int WR_BITS = 8 * (3 + SNAPSHOT_BYTES);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_WREN  = 3'd2,
      ST_GAP   = 3'd3,
      ST_WRITE = 3'd4,
      ST_DONE  = 3'd5
   } state_e;

   typedef struct packed {
      logic [7:0] b0;
      logic [7:0] b1;
      logic [7:0] b2;
      logic [7:0] b3;
   } snap_t;

   function automatic snap_t pack_snap(
      input logic [7:0] es,
      input logic [7:0] act,
      input logic [1:0] stage,
      input logic [9:0] nt
   );
      snap_t s;
      s.b0 = es;
      s.b1 = act;
      s.b2 = {stage, 4'b0000, nt[9:8]};
      s.b3 = nt[7:0];
      return s;
   endfunction

endpackage

// File: rtl/fram_state_logger_if.sv
// Request/status and SPI signals of the FRAM state logger.
// slave = logger side, master = requester/arbiter/FRAM side.
interface fram_state_logger_if #(
   parameter int NUM_SLOTS = 8
);
   localparam int SW = $clog2(NUM_SLOTS);

   logic          start;
   logic [7:0]    emotional_state;
   logic [7:0]    action;
   logic [1:0]    development_stage;
   logic [9:0]    neurotransmitter_level;
   logic          bus_gnt;
   logic          bus_req;
   logic          spi_sck;
   logic          spi_cs;
   logic          spi_mosi;
   logic          busy;
   logic          done;
   logic [SW-1:0] slot;
   logic          overrun;

   modport master (
      output start, emotional_state, action,
      output development_stage, neurotransmitter_level,
      output bus_gnt,
      input  bus_req, spi_sck, spi_cs, spi_mosi,
      input  busy, done, slot, overrun
   );

   modport slave (
      input  start, emotional_state, action,
      input  development_stage, neurotransmitter_level,
      input  bus_gnt,
      output bus_req, spi_sck, spi_cs, spi_mosi,
      output busy, done, slot, overrun
   );

endinterface

// File: rtl/fram_state_logger_shifter.sv
// Mode-0 SPI serializer: two cycles per bit, sck low then high,
// MSB first, up to 56 bits per load.
module spi_tx_shifter (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        load_i,
   input  logic [55:0] data_i,
   input  logic [5:0]  nbits_i,
   output logic        sck_o,
   output logic        mosi_o,
   output logic        last_o
);

   logic [55:0] sr_q, sr_d;
   logic [5:0]  cnt_q, cnt_d;
   logic        ph_q, ph_d;
   logic        act_q, act_d;
   logic        sck_q, sck_d;
   logic        mosi_q, mosi_d;

   assign last_o = act_q & ph_q & (cnt_q == 6'd1);
   assign sck_o  = sck_q;
   assign mosi_o = mosi_q;

   // shift/phase sequencing; mosi drops to 0 once the last bit ends
   always_comb begin
      sr_d   = sr_q;
      cnt_d  = cnt_q;
      ph_d   = ph_q;
      act_d  = act_q;
      sck_d  = sck_q;
      mosi_d = mosi_q;
      if (load_i) begin
         sr_d   = data_i;
         cnt_d  = nbits_i;
         ph_d   = 1'b0;
         act_d  = 1'b1;
         sck_d  = 1'b0;
         mosi_d = data_i[55];
      end else if (act_q) begin
         if (!ph_q) begin
            ph_d  = 1'b1;
            sck_d = 1'b1;
         end else if (last_o) begin
            act_d  = 1'b0;
            ph_d   = 1'b0;
            sck_d  = 1'b0;
            mosi_d = 1'b0;
         end else begin
            sr_d   = sr_q << 1;
            cnt_d  = cnt_q - 6'd1;
            ph_d   = 1'b0;
            sck_d  = 1'b0;
            mosi_d = sr_q[54];
         end
      end
   end

   // shifter registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sr_q   <= '0;
         cnt_q  <= '0;
         ph_q   <= 1'b0;
         act_q  <= 1'b0;
         sck_q  <= 1'b0;
         mosi_q <= 1'b0;
      end else begin
         sr_q   <= sr_d;
         cnt_q  <= cnt_d;
         ph_q   <= ph_d;
         act_q  <= act_d;
         sck_q  <= sck_d;
         mosi_q <= mosi_d;
      end
   end

endmodule

// File: rtl/fram_state_logger.sv
// Writes 4-byte state snapshots into a ring of FRAM slots:
// bus request, WREN, cs gap, WRITE with address and record.
module fram_state_logger
   import fram_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = 16'h7F00,
   parameter int          NUM_SLOTS = 8
) (
   input logic               clk_model,
   input logic               rst_n,
   fram_state_logger_if.slave bus
);

   localparam int SW = $clog2(NUM_SLOTS);

   state_e        state_q, state_d;
   snap_t         rec_q, rec_d;
   logic [SW-1:0] slot_q, slot_d;
   logic          gap_q, gap_d;
   logic          ovr_q, ovr_d;
   logic          req_q, req_d;
   logic          cs_q, cs_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic          ld;
   logic [55:0]   ld_data;
   logic [5:0]    ld_bits;
   logic          sh_last;
   logic          sh_sck;
   logic          sh_mosi;
   logic [15:0]   addr;

   assign addr = BASE_ADDR + 16'({slot_q, 2'b00});

   spi_tx_shifter u_shift (
      .clk_i   (clk_model),
      .rst_ni  (rst_n),
      .load_i  (ld),
      .data_i  (ld_data),
      .nbits_i (ld_bits),
      .sck_o   (sh_sck),
      .mosi_o  (sh_mosi),
      .last_o  (sh_last)
   );

   // state, record, slot and registered outputs
   always_ff @(posedge clk_model or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         rec_q   <= '0;
         slot_q  <= '0;
         gap_q   <= 1'b0;
         ovr_q   <= 1'b0;
         req_q   <= 1'b0;
         cs_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rec_q   <= rec_d;
         slot_q  <= slot_d;
         gap_q   <= gap_d;
         ovr_q   <= ovr_d;
         req_q   <= req_d;
         cs_q    <= cs_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // next state; loads the shifter on entry to WREN and WRITE
   always_comb begin
      state_d = state_q;
      rec_d   = rec_q;
      slot_d  = slot_q;
      gap_d   = 1'b0;
      ovr_d   = ovr_q | (bus.start & (state_q != ST_IDLE));
      ld      = 1'b0;
      ld_data = {FRAM_OP_WREN, 48'h0};
      ld_bits = 6'd8;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_REQ;
               rec_d   = pack_snap(bus.emotional_state, bus.action,
                                   bus.development_stage,
                                   bus.neurotransmitter_level);
            end
         end
         ST_REQ: begin
            if (bus.bus_gnt) begin
               state_d = ST_WREN;
               ld      = 1'b1;
            end
         end
         ST_WREN: begin
            if (sh_last) state_d = ST_GAP;
         end
         ST_GAP: begin
            gap_d = ~gap_q;
            if (gap_q) begin
               state_d = ST_WRITE;
               ld      = 1'b1;
               ld_data = {FRAM_OP_WRITE, addr, rec_q};
               ld_bits = 6'(WR_BITS);
            end
         end
         ST_WRITE: begin
            if (sh_last) state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            slot_d  = slot_q + 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // outputs decoded from the next state so they are registered
   always_comb begin
      req_d  = state_d inside {ST_REQ, ST_WREN, ST_GAP, ST_WRITE};
      cs_d   = !(state_d inside {ST_WREN, ST_WRITE});
      busy_d = state_d != ST_IDLE;
      done_d = state_d == ST_DONE;
   end

   assign bus.bus_req  = req_q;
   assign bus.spi_sck  = sh_sck;
   assign bus.spi_cs   = cs_q;
   assign bus.spi_mosi = sh_mosi;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.slot     = slot_q;
   assign bus.overrun  = ovr_q;

endmodule

// File: tb/tb_fram_state_logger.sv
// Directed table-driven bench for fram_state_logger: captures the
// SPI frames, checks timing, slot ring, overrun and async reset.
module tb_fram_state_logger;

   typedef struct {
      logic [7:0]  es;
      logic [7:0]  act;
      logic [1:0]  st;
      logic [9:0]  nt;
      logic [55:0] exp_wr;
      logic [2:0]  exp_slot;
   } vec_t;

   vec_t tbl [9];

   logic clk_model = 1'b0;
   logic rst_n = 1'b0;

   int n_vec = 0;
   int n_bad = 0;
   int cur = -1;

   int          segn[$];
   logic [63:0] segd[$];
   int          gaps[$];
   logic [63:0] sbits = '0;
   int          scnt = 0;
   int          hi_cnt = 0;
   int          viol = 0;
   int          sck_hi = 0;
   logic        prev_sck = 1'b0;
   logic        prev_cs = 1'b1;

   fram_state_logger_if #(.NUM_SLOTS(8)) ifc ();

   fram_state_logger #(
      .BASE_ADDR (16'h7F00),
      .NUM_SLOTS (8)
   ) dut (
      .clk_model (clk_model),
      .rst_n     (rst_n),
      .bus       (ifc.slave)
   );

   always #5 clk_model = ~clk_model;

   // SPI monitor sampled once per cycle on the falling clock edge
   always @(negedge clk_model) begin
      if (ifc.spi_sck && !prev_sck) begin
         if (ifc.spi_cs) sck_hi++;
         else begin
            sbits = {sbits[62:0], ifc.spi_mosi};
            scnt++;
         end
      end
      if (ifc.spi_cs && !prev_cs) begin
         segn.push_back(scnt);
         segd.push_back(sbits);
         scnt  = 0;
         sbits = '0;
      end
      if (ifc.spi_cs) hi_cnt++;
      else begin
         if (prev_cs) gaps.push_back(hi_cnt);
         hi_cnt = 0;
      end
      if (ifc.spi_cs && (ifc.spi_sck || ifc.spi_mosi)) viol++;
      prev_sck = ifc.spi_sck;
      prev_cs  = ifc.spi_cs;
   end

   task automatic chk(input string nm, input logic [63:0] a,
                      input logic [63:0] e);
      n_vec++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s (vec %0d): got %0h, expected %0h",
                  nm, cur, a, e);
      end
   endtask

   // gw: cycles gnt held low; ov: cycle of stray start; ab: reset cycle
   task automatic run_rec(input int i, input int gw, input int ov,
                          input int ab);
      int done_k = -1;
      int stall = 0;
      bit aborted = 0;
      cur = i;
      segn.delete();
      segd.delete();
      gaps.delete();
      ifc.emotional_state        = tbl[i].es;
      ifc.action                 = tbl[i].act;
      ifc.development_stage      = tbl[i].st;
      ifc.neurotransmitter_level = tbl[i].nt;
      ifc.bus_gnt                = (gw == 0);
      ifc.start                  = 1'b1;
      for (int k = 1; k <= 400 && done_k < 0 && !aborted; k++) begin
         @(negedge clk_model);
         if (k == 1) begin
            ifc.start                  = 1'b0;
            ifc.emotional_state        = ~tbl[i].es;
            ifc.action                 = ~tbl[i].act;
            ifc.development_stage      = ~tbl[i].st;
            ifc.neurotransmitter_level = ~tbl[i].nt;
            chk("req_busy", {ifc.bus_req, ifc.busy}, 2'b11);
         end
         if (k <= gw && !(ifc.bus_req && ifc.spi_cs && !ifc.spi_sck))
            stall++;
         if (k == gw) ifc.bus_gnt = 1'b1;
         if (k == ov) ifc.start = 1'b1;
         if (ov > 0 && k == ov + 1) begin
            ifc.start = 1'b0;
            chk("overrun_set", ifc.overrun, 1);
         end
         if (k == ab) begin
            #2 rst_n = 1'b0;
            #1;
            chk("abort_out", {ifc.spi_cs, ifc.spi_sck, ifc.spi_mosi,
                ifc.bus_req, ifc.busy, ifc.done}, 6'b100000);
            @(negedge clk_model);
            rst_n = 1'b1;
            @(negedge clk_model);
            chk("abort_slot", {ifc.slot, ifc.overrun}, 4'b0000);
            @(negedge clk_model);
            aborted = 1;
         end
         if (ifc.done) done_k = k;
      end
      if (!aborted) begin
         chk("done_cycle", done_k, (gw > 0) ? gw + 131 : 132);
         @(negedge clk_model);
         chk("done_pulse", {ifc.done, ifc.busy}, 0);
         chk("wren_bits", segn.size() >= 1 ? segn[0] : -1, 8);
         chk("wren_data", segd.size() >= 1 ? segd[0] : '1, 64'h06);
         chk("write_bits", segn.size() >= 2 ? segn[1] : -1, 56);
         chk("write_data", segd.size() >= 2 ? segd[1] : '1,
             {8'h00, tbl[i].exp_wr});
         chk("cs_gap", gaps.size() >= 2 ? gaps[1] : -1, 2);
         chk("slot", ifc.slot, tbl[i].exp_slot);
         if (gw > 0) chk("req_hold", stall, 0);
      end
   endtask

   initial begin
      tbl[0] = '{8'hA5, 8'h3C, 2'd2, 10'h2F1, 56'h027F00A53C82F1, 3'd1};
      tbl[1] = '{8'h01, 8'h02, 2'd0, 10'h000, 56'h027F0401020000, 3'd2};
      tbl[2] = '{8'hFF, 8'hFF, 2'd3, 10'h3FF, 56'h027F08FFFFC3FF, 3'd3};
      tbl[3] = '{8'h10, 8'h20, 2'd1, 10'h155, 56'h027F0C10204155, 3'd4};
      tbl[4] = '{8'h80, 8'h7E, 2'd2, 10'h2AA, 56'h027F10807E82AA, 3'd5};
      tbl[5] = '{8'h5A, 8'hC3, 2'd0, 10'h300, 56'h027F145AC30300, 3'd6};
      tbl[6] = '{8'h00, 8'h99, 2'd3, 10'h0FF, 56'h027F180099C0FF, 3'd7};
      tbl[7] = '{8'h77, 8'h01, 2'd1, 10'h100, 56'h027F1C77014100, 3'd0};
      tbl[8] = '{8'h3C, 8'hA5, 2'd2, 10'h0F1, 56'h027F003CA580F1, 3'd1};

      ifc.start                  = 1'b0;
      ifc.emotional_state        = '0;
      ifc.action                 = '0;
      ifc.development_stage      = '0;
      ifc.neurotransmitter_level = '0;
      ifc.bus_gnt                = 1'b1;
      rst_n                      = 1'b0;
      repeat (3) @(negedge clk_model);
      chk("rst_bus_req", ifc.bus_req, 0);
      chk("rst_sck", ifc.spi_sck, 0);
      chk("rst_cs", ifc.spi_cs, 1);
      chk("rst_mosi", ifc.spi_mosi, 0);
      chk("rst_busy", ifc.busy, 0);
      chk("rst_done", ifc.done, 0);
      chk("rst_slot", ifc.slot, 0);
      chk("rst_overrun", ifc.overrun, 0);
      rst_n = 1'b1;
      @(negedge clk_model);

      for (int i = 0; i < 9; i++) run_rec(i, 0, 0, 0);
      chk("no_overrun_b2b", ifc.overrun, 0);

      run_rec(1, 50, 0, 0);

      run_rec(2, 0, 20, 0);
      chk("overrun_sticky", ifc.overrun, 1);

      run_rec(3, 0, 0, 80);

      run_rec(0, 0, 0, 0);
      chk("overrun_after_rst", ifc.overrun, 0);

      cur = -1;
      chk("cs_hi_quiet", viol, 0);
      chk("sck_while_cs_hi", sck_hi, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
